// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - SPI receive front-end: CDC, 0xFF header hunt, payload bit deserialiser
module spi_frame_rx #(
  parameter int        MEM_BITS       = 48,
  parameter int        NUM_MEMS       = 15,
  parameter logic [7:0] HEADER        = 8'hFF,
  parameter int        SYNC_STAGES    = 2,
  parameter int        TIMEOUT_CYCLES = 400
) (
  input  logic                            CLK_40,
  input  logic                            reset_n,
  input  logic                            SPI_clk_CDC,
  input  logic                            MISO_CDC,
  input  logic                            rx_enable,
  output logic                            bit_valid,
  output logic                            bit_data,
  output logic [$clog2(NUM_MEMS+1)-1:0]   mem_sel,
  output logic [$clog2(MEM_BITS)-1:0]     bit_addr,
  output logic                            frame_done,
  output logic                            rx_error,
  output logic                            busy
);

  localparam int SEL_W  = $clog2(NUM_MEMS + 1);
  localparam int ADDR_W = $clog2(MEM_BITS);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(NUM_MEMS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BITS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HUNT, PAYLOAD, DONE} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] miso_sync;
  logic                   clk_hist;
  logic                   spi_rise;
  logic                   miso_s;

  logic [7:0]        shreg;
  logic [7:0]        shreg_next;
  logic [SEL_W-1:0]  cnt_sel;
  logic [ADDR_W-1:0] cnt_addr;
  logic [TO_W-1:0]   idle_cnt;
  logic              last_bit;

  logic do_init;
  logic do_shift;
  logic do_strobe;
  logic do_done;
  logic do_err;

  assign spi_rise   = clk_sync[SYNC_STAGES-1] & ~clk_hist;
  assign miso_s     = miso_sync[SYNC_STAGES-1];
  assign shreg_next = {shreg[6:0], miso_s};
  assign last_bit   = (cnt_sel == LAST_SEL) && (cnt_addr == LAST_ADDR);
  assign busy       = (state == HUNT) || (state == PAYLOAD);

  // Bring SPI clock and data into CLK_40; history FF turns the synced clock into an edge pulse
  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '0;
      miso_sync <= '0;
      clk_hist  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], SPI_clk_CDC};
      miso_sync <= {miso_sync[SYNC_STAGES-2:0], MISO_CDC};
      clk_hist  <= clk_sync[SYNC_STAGES-1];
    end
  end

  // State register
  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state and control decode; dropping rx_enable beats any coincident SPI edge
  always_comb begin
    next_state = state;
    do_init    = 1'b0;
    do_shift   = 1'b0;
    do_strobe  = 1'b0;
    do_done    = 1'b0;
    do_err     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_enable) begin
          next_state = HUNT;
          do_init    = 1'b1;
        end
      end
      HUNT: begin
        if (!rx_enable) begin
          next_state = IDLE;
        end else if (spi_rise) begin
          do_shift = 1'b1;
          if (shreg_next == HEADER) next_state = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!rx_enable) begin
          next_state = IDLE;
        end else if (spi_rise) begin
          do_strobe = 1'b1;
          if (last_bit) begin
            do_done    = 1'b1;
            next_state = DONE;
          end
        end else if (idle_cnt == TO_LAST) begin
          do_err     = 1'b1;
          do_init    = 1'b1;
          next_state = HUNT;
        end
      end
      DONE: begin
        if (!rx_enable) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Shift register, address counters, idle timer and registered output strobes
  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      cnt_sel    <= '0;
      cnt_addr   <= '0;
      idle_cnt   <= '0;
      bit_valid  <= 1'b0;
      bit_data   <= 1'b0;
      mem_sel    <= '0;
      bit_addr   <= '0;
      frame_done <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      bit_valid  <= do_strobe;
      frame_done <= do_done;
      rx_error   <= do_err;

      if (do_init) begin
        shreg    <= '0;
        cnt_sel  <= SEL_W'(1);
        cnt_addr <= '0;
        idle_cnt <= '0;
      end else begin
        if (do_shift) shreg <= shreg_next;

        if (state == PAYLOAD) begin
          if (spi_rise) idle_cnt <= '0;
          else          idle_cnt <= idle_cnt + TO_W'(1);
        end else begin
          idle_cnt <= '0;
        end

        if (do_strobe) begin
          bit_data <= miso_s;
          mem_sel  <= cnt_sel;
          bit_addr <= cnt_addr;
          if (cnt_addr == LAST_ADDR) begin
            cnt_addr <= '0;
            cnt_sel  <= cnt_sel + SEL_W'(1);
          end else begin
            cnt_addr <= cnt_addr + ADDR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb/tb_spi_frame_rx.sv - scoreboard bench for spi_frame_rx
`timescale 1ns/1ps
module tb_spi_frame_rx;

  logic       CLK_40;
  logic       reset_n;
  logic       SPI_clk_CDC;
  logic       MISO_CDC;
  logic       rx_enable;
  logic       bit_valid;
  logic       bit_data;
  logic [3:0] mem_sel;
  logic [5:0] bit_addr;
  logic       frame_done;
  logic       rx_error;
  logic       busy;

  spi_frame_rx dut (
    .CLK_40     (CLK_40),
    .reset_n    (reset_n),
    .SPI_clk_CDC(SPI_clk_CDC),
    .MISO_CDC   (MISO_CDC),
    .rx_enable  (rx_enable),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .mem_sel    (mem_sel),
    .bit_addr   (bit_addr),
    .frame_done (frame_done),
    .rx_error   (rx_error),
    .busy       (busy)
  );

  // Slice image of the {BB,A0,D2,BB,A0,D2} payload, bit n = RAM address n
  localparam logic [47:0] EXP_IMG = 48'h4B05_DD4B_05DD;

  typedef struct {
    logic       d;
    logic [3:0] sel;
    logic [5:0] addr;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp;
  int n_bad;
  int n_valid;
  int n_done;
  int n_err;

  initial CLK_40 = 1'b0;
  always #12.5 CLK_40 = ~CLK_40;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] pat_byte(input int i);
    case (i % 6)
      0, 3:    return 8'hBB;
      1, 4:    return 8'hA0;
      default: return 8'hD2;
    endcase
  endfunction

  function automatic logic pat_bit(input int k);
    logic [7:0] b;
    b = pat_byte(k / 8);
    return b[7 - (k % 8)];
  endfunction

  task automatic push_frame(input int nbits, input bit ones);
    exp_t e;
    for (int k = 0; k < nbits; k++) begin
      e.addr = 6'(k % 48);
      e.sel  = 4'(k / 48 + 1);
      e.d    = ones ? 1'b1 : EXP_IMG[k % 48];
      e.done = (k == 719);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_bit(input logic b, input bit jit);
    int h1, h2;
    h1 = jit ? 450 + $urandom_range(0, 100) : 450;
    h2 = jit ? 450 + $urandom_range(0, 100) : 450;
    MISO_CDC = b;
    #(h1);
    SPI_clk_CDC = 1'b1;
    #(h2);
    SPI_clk_CDC = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit jit);
    for (int i = 7; i >= 0; i--) send_bit(b[i], jit);
    if (jit) #(200 + $urandom_range(0, 100));
  endtask

  // Monitor: every strobe pops the scoreboard and is compared with its expected entry
  always @(negedge CLK_40) begin
    exp_t e;
    if (bit_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_bit_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("bit_strobe", {bit_data, mem_sel, bit_addr, frame_done},
              {e.d, e.sel, e.addr, e.done});
      end
    end else if (frame_done) begin
      check("frame_done_without_bit", 1, 0);
    end
    if (frame_done) n_done++;
    if (rx_error)   n_err++;
  end

  initial begin
    int v0, d0, e0;
    n_cmp = 0; n_bad = 0; n_valid = 0; n_done = 0; n_err = 0;
    reset_n = 1'b0; rx_enable = 1'b0; SPI_clk_CDC = 1'b0; MISO_CDC = 1'b0;

    #100;
    @(negedge CLK_40);
    check("reset_outputs", {bit_valid, bit_data, mem_sel, bit_addr, frame_done, rx_error, busy}, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge CLK_40);
    check("idle_busy", busy, 0);

    // Reset asserted mid-payload
    rx_enable = 1'b1;
    #200;
    check("hunt_busy", busy, 1);
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    v0 = n_valid;
    push_frame(20, 0);
    for (int k = 0; k < 20; k++) send_bit(pat_bit(k), 0);
    #300;
    check("t1_strobes", n_valid - v0, 20);
    check("t1_payload_busy", busy, 1);
    reset_n = 1'b0;
    rx_enable = 1'b0;
    #1;
    check("t1_reset_outputs", {bit_valid, bit_data, mem_sel, bit_addr, frame_done, rx_error, busy}, 0);
    #100;
    @(negedge CLK_40);
    reset_n = 1'b1;
    repeat (5) @(negedge CLK_40);
    check("t1_idle_after_release", busy, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // Full frame with jitter, inter-byte gaps and long mid-frame gaps
    v0 = n_valid; d0 = n_done; e0 = n_err;
    rx_enable = 1'b1;
    #200;
    repeat (9) send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    push_frame(720, 0);
    for (int i = 0; i < 90; i++) begin
      send_byte(pat_byte(i), 1);
      if (i == 29 || i == 59) #(1000 + $urandom_range(0, 2000));
    end
    #2000;
    check("t2_bit_count", n_valid - v0, 720);
    check("t2_frame_done", n_done - d0, 1);
    check("t2_rx_error", n_err - e0, 0);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_done_not_busy", busy, 0);
    rx_enable = 1'b0;
    #500;

    // Timeout abort, then a clean frame of 0xFF data with trailing 0x00 bytes
    v0 = n_valid; d0 = n_done; e0 = n_err;
    rx_enable = 1'b1;
    #200;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    push_frame(100, 0);
    for (int k = 0; k < 100; k++) send_bit(pat_bit(k), 0);
    #12000;
    check("t4_timeout_error", n_err - e0, 1);
    check("t4_partial_bits", n_valid - v0, 100);
    check("t4_no_frame_done", n_done - d0, 0);
    check("t4_hunt_busy", busy, 1);
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    push_frame(720, 1);
    repeat (90) send_byte(8'hFF, 0);
    repeat (3) send_byte(8'h00, 0);
    #1000;
    check("t6_bit_count", n_valid - v0, 820);
    check("t6_frame_done", n_done - d0, 1);
    check("t6_single_error", n_err - e0, 1);
    check("t6_queue_empty", exp_q.size(), 0);
    rx_enable = 1'b0;
    #500;

    // rx_enable dropped mid-payload
    v0 = n_valid; d0 = n_done; e0 = n_err;
    rx_enable = 1'b1;
    #200;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    push_frame(300, 0);
    for (int k = 0; k < 300; k++) send_bit(pat_bit(k), 0);
    rx_enable = 1'b0;
    @(posedge CLK_40);
    #1;
    check("t5_busy_drop", busy, 0);
    for (int k = 300; k < 316; k++) send_bit(pat_bit(k), 0);
    #1000;
    check("t5_bit_count", n_valid - v0, 300);
    check("t5_no_frame_done", n_done - d0, 0);
    check("t5_no_error", n_err - e0, 0);
    check("t5_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
